comperator_axi_ip_v1_0_block_sequencer: RTL
===========================================

Name: comperator_axi_ip_v1_0_block_sequencer

Overview:
Sequences the distance unit across all blocks of one block-row. After upstream sums are ready, it steps `count` 0..NUM_BLOCKS-1, pulses `go`, waits for `done`, and captures `grayscaled_pixel` into a small result buffer. It then expands the buffered results into BLOCK_SIZE full-width output lines on an AXI4-Stream master. It sits between the SAD-sum stage and the video output DMA.

Parameters:
- FRAME_WIDTH, 320: pixels per line.
- FRAME_HEIGHT, 240: lines per frame; must be a multiple of BLOCK_SIZE.
- BLOCK_SIZE, 8: block edge in pixels; FRAME_WIDTH must be a multiple of it.
- DATA_WIDTH, 24: output pixel width.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse: sums for the current block-row are valid and stable until `row_done`.
- busy  out  1  high from the start acceptance edge until row_done.
- row_done  out  1  one-cycle pulse after the last output pixel of the block-row is accepted.
- count  out  16  block index to the distance unit.
- go  out  1  one-cycle start pulse to the distance unit.
- dist_done  in  1  distance unit done level.
- grayscaled_pixel  in  DATA_WIDTH  distance unit result.
- m_axis_tdata  out  DATA_WIDTH  output pixel.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  output ready.
- m_axis_tlast  out  1  last pixel of each line.
- m_axis_tuser  out  1  first pixel of the frame.

Behaviour:
- Reset (async assert, sync deassert inside the block):
  - All outputs 0.
  - State IDLE.
  - blk_row counter 0.
  - Result buffer contents don't-care.
- States: IDLE, ISSUE, GAP, WAIT, CAPTURE, EMIT.
- IDLE:
  - When start=1: count<=0, busy<=1, go to ISSUE.
  - start in any other state is ignored (no queuing).
- ISSUE: go=1 for exactly this one cycle, then GAP.
  - Start-to-go latency: go is high in the cycle after start is sampled.
- GAP: one dead cycle, so a stale dist_done from the previous block is never sampled. Then WAIT.
- WAIT: stay until dist_done=1, then CAPTURE. No timeout.
- CAPTURE:
  - buf[count] <= grayscaled_pixel.
  - If count==NUM_BLOCKS-1: go to EMIT, reset pixel/line counters.
  - Else: count<=count+1, go to ISSUE.
- count is held stable from ISSUE through CAPTURE; the distance unit reads it in its pixelize step.
- NUM_BLOCKS = FRAME_WIDTH/BLOCK_SIZE.
- Buffer: NUM_BLOCKS x DATA_WIDTH registers, one write port, one read port.
- EMIT:
  - Streams BLOCK_SIZE lines of FRAME_WIDTH pixels each.
  - Pixel x of every line has tdata = buf[x / BLOCK_SIZE]. Implement with a sub-block pixel counter plus a block counter; no divider.
  - tlast=1 at x==FRAME_WIDTH-1.
  - tuser=1 only on x==0 of line 0 when blk_row==0.
- AXI rules:
  - tvalid, once raised, stays high until the transfer completes.
  - tdata, tlast and tuser must not change while tvalid=1 and tready=0.
  - Counters advance only on tvalid&&tready.
  - No bubbles are required while tready stays high (one pixel per cycle).
- End of block-row: after the transfer of the last pixel (line BLOCK_SIZE-1, x=FRAME_WIDTH-1):
  - row_done pulses for one cycle and busy<=0.
  - blk_row increments and wraps to 0 after FRAME_HEIGHT/BLOCK_SIZE-1.
  - State returns to IDLE.
- start arriving in the same cycle as row_done is ignored.
- Reset mid-operation: everything returns to reset values immediately. tvalid drops without completing the stream. The frame restarts at blk_row 0.
- Widths: all counters sized with $clog2 of their range. count is zero-extended to 16 bits.

Decomposition:
- Shared package (comperator_pkg) holds:
  - DATA_WIDTH.
  - Derived localparams NUM_BLOCKS and NUM_BLOCK_ROWS.
  - The state encoding constants.
- One natural sub-module: comperator_axi_ip_v1_0_result_buf, the NUM_BLOCKS-entry register file with a synchronous write and a combinational read.
- The FSM and stream counters stay in the top module.

Test Plan:
- Single block-row, defaults. Distance model returns done 5 cycles after go with pixel = {8'h0, 8'h0, count[7:0]}, tready=1.
  - Expect 40 go pulses with count 0..39, each go preceded by the prior done.
  - Then 8 lines x 320 beats; beat x has tdata = x/8.
  - tlast on beats 319, 639, …; tuser only on beat 0; row_done exactly once, after beat 2559.
- Stale done: the model holds dist_done=1 continuously until 1 cycle after go.
  - Expect every capture to take the new pixel value, never the previous one.
- Backpressure: random tready at 30% duty.
  - Expect the output sequence identical to the first test.
  - Expect no tdata/tlast/tuser change while tvalid&&!tready.
- Frame wrap: 31 consecutive block-rows.
  - Expect tuser on the first beat of rows 0 and 30 only, and blk_row back to 0 after row 29.
- start while busy: pulse start during WAIT and during EMIT.
  - Expect no extra go pulses, count unchanged, output sequence unaffected.
- Reset mid-EMIT: assert aresetn=0 at beat 100 of line 2.
  - Expect all outputs 0 asynchronously and state IDLE.
  - Expect the next start to produce tuser on its first beat.

Source files
------------

// File: rtl/comperator_pkg.sv
`default_nettype none
// ============================================================================
// comperator_pkg - shared constants and state encoding for the block sequencer
// Revision: 1.0
// ============================================================================
package comperator_pkg;

  localparam int FRAME_WIDTH    = 320;
  localparam int FRAME_HEIGHT   = 240;
  localparam int BLOCK_SIZE     = 8;
  localparam int DATA_WIDTH     = 24;

  localparam int NUM_BLOCKS     = FRAME_WIDTH / BLOCK_SIZE;
  localparam int NUM_BLOCK_ROWS = FRAME_HEIGHT / BLOCK_SIZE;

  localparam int STATE_W = 3;
  localparam logic [STATE_W-1:0] S_IDLE    = 3'd0;
  localparam logic [STATE_W-1:0] S_ISSUE   = 3'd1;
  localparam logic [STATE_W-1:0] S_GAP     = 3'd2;
  localparam logic [STATE_W-1:0] S_WAIT    = 3'd3;
  localparam logic [STATE_W-1:0] S_CAPTURE = 3'd4;
  localparam logic [STATE_W-1:0] S_EMIT    = 3'd5;

  // Counter width for a range of n values; never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/comperator_axi_ip_v1_0_result_buf.sv
`default_nettype none
// ============================================================================
// comperator_axi_ip_v1_0_result_buf - per-block result register file
// Revision: 1.0
// ============================================================================
module comperator_axi_ip_v1_0_result_buf
  import comperator_pkg::*;
#(
  parameter  int DEPTH = NUM_BLOCKS,
  parameter  int WIDTH = DATA_WIDTH,
  localparam int AW    = clog2_min1(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Contents are don't-care after reset, so no reset term on the storage.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule
`default_nettype wire

// File: rtl/comperator_axi_ip_v1_0_block_sequencer.sv
`default_nettype none
// ============================================================================
// comperator_axi_ip_v1_0_block_sequencer - runs the distance unit over one
// block-row, then streams it as BLOCK_SIZE full lines on AXI4-Stream.
// Revision: 1.0
// ============================================================================
module comperator_axi_ip_v1_0_block_sequencer #(
  parameter int FRAME_WIDTH  = comperator_pkg::FRAME_WIDTH,
  parameter int FRAME_HEIGHT = comperator_pkg::FRAME_HEIGHT,
  parameter int BLOCK_SIZE   = comperator_pkg::BLOCK_SIZE,
  parameter int DATA_WIDTH   = comperator_pkg::DATA_WIDTH
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  start,
  output logic                  busy,
  output logic                  row_done,
  output logic [15:0]           count,
  output logic                  go,
  input  logic                  dist_done,
  input  logic [DATA_WIDTH-1:0] grayscaled_pixel,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser
);
  import comperator_pkg::*;

  localparam int N_BLK  = FRAME_WIDTH / BLOCK_SIZE;
  localparam int N_ROWS = FRAME_HEIGHT / BLOCK_SIZE;
  localparam int CNT_W  = clog2_min1(N_BLK);
  localparam int PIX_W  = clog2_min1(BLOCK_SIZE);
  localparam int ROW_W  = clog2_min1(N_ROWS);

  localparam logic [CNT_W-1:0] LAST_BLK  = CNT_W'(N_BLK - 1);
  localparam logic [PIX_W-1:0] LAST_PIX  = PIX_W'(BLOCK_SIZE - 1);
  localparam logic [ROW_W-1:0] LAST_ROW  = ROW_W'(N_ROWS - 1);

  logic [1:0]         rst_sync_q;
  logic               rst_n;
  logic [STATE_W-1:0] state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PIX_W-1:0]   pix_q, pix_d;
  logic [CNT_W-1:0]   blk_q, blk_d;
  logic [PIX_W-1:0]   line_q, line_d;
  logic [ROW_W-1:0]   blk_row_q, blk_row_d;
  logic               busy_q, busy_d;
  logic               row_done_q, row_done_d;
  logic [DATA_WIDTH-1:0] rd_data;

  // Reset asserts asynchronously and releases two clocks after aresetn rises.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end
  assign rst_n = rst_sync_q[1];

  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      pix_q      <= '0;
      blk_q      <= '0;
      line_q     <= '0;
      blk_row_q  <= '0;
      busy_q     <= 1'b0;
      row_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      pix_q      <= pix_d;
      blk_q      <= blk_d;
      line_q     <= line_d;
      blk_row_q  <= blk_row_d;
      busy_q     <= busy_d;
      row_done_q <= row_done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    pix_d      = pix_q;
    blk_d      = blk_q;
    line_d     = line_q;
    blk_row_d  = blk_row_q;
    busy_d     = busy_q;
    row_done_d = 1'b0;
    case (state_q)
      // A start coinciding with the row_done pulse is dropped, not queued.
      S_IDLE: begin
        if (start && !row_done_q) begin
          count_d = '0;
          busy_d  = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_GAP;
      S_GAP:   state_d = S_WAIT;
      S_WAIT: begin
        if (dist_done) begin
          state_d = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        if (count_q == LAST_BLK) begin
          pix_d   = '0;
          blk_d   = '0;
          line_d  = '0;
          state_d = S_EMIT;
        end else begin
          count_d = count_q + CNT_W'(1);
          state_d = S_ISSUE;
        end
      end
      S_EMIT: begin
        if (m_axis_tready) begin
          if (pix_q != LAST_PIX) begin
            pix_d = pix_q + PIX_W'(1);
          end else begin
            pix_d = '0;
            if (blk_q != LAST_BLK) begin
              blk_d = blk_q + CNT_W'(1);
            end else begin
              blk_d = '0;
              if (line_q != LAST_PIX) begin
                line_d = line_q + PIX_W'(1);
              end else begin
                state_d    = S_IDLE;
                busy_d     = 1'b0;
                row_done_d = 1'b1;
                blk_row_d  = (blk_row_q == LAST_ROW) ? '0 : blk_row_q + ROW_W'(1);
              end
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Stream fields depend only on registered counters, so they hold under stall.
  always_comb begin
    go            = (state_q == S_ISSUE);
    m_axis_tvalid = (state_q == S_EMIT);
    m_axis_tdata  = m_axis_tvalid ? rd_data : '0;
    m_axis_tlast  = m_axis_tvalid && (blk_q == LAST_BLK) && (pix_q == LAST_PIX);
    m_axis_tuser  = m_axis_tvalid && (blk_row_q == '0) && (line_q == '0) &&
                    (blk_q == '0) && (pix_q == '0);
  end

  assign busy     = busy_q;
  assign row_done = row_done_q;
  assign count    = 16'(count_q);

  comperator_axi_ip_v1_0_result_buf #(
    .DEPTH (N_BLK),
    .WIDTH (DATA_WIDTH)
  ) u_result_buf (
    .clk     (aclk),
    .wr_en   (state_q == S_CAPTURE),
    .wr_addr (count_q),
    .wr_data (grayscaled_pixel),
    .rd_addr (blk_q),
    .rd_data (rd_data)
  );

endmodule
`default_nettype wire
